// File: rtl/vga_avl_pkg.sv
// Shared definitions for the VGA text/tank slave and the Avalon copy master that feeds it.
package vga_avl_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 12;

  // Word addresses in the VGA slave register map.
  localparam int unsigned PALETTE_BASE  = 2048;
  localparam int unsigned CTRL_REG      = 2056;
  localparam int unsigned WALL_POS_BASE = 2067;
  localparam int unsigned VRAM_WORDS    = 1200;

  localparam int unsigned LAT_CNT_W   = 2;
  localparam logic [3:0]  BYTE_EN_ALL = 4'hF;

  typedef enum logic [2:0] {
    CopyIdle,
    CopyRdReq,
    CopyRdWait,
    CopyWrReq,
    CopyFinish
  } copy_state_t;

endpackage

// File: rtl/avl_copy_latency_ctr.sv
// Load/decrement counter that times the fixed slave read latency after a read is accepted.
module avl_copy_latency_ctr #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High in the final wait cycle, which is the cycle the read data is valid on the bus.
  assign expired = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/avl_copy_master.sv
// Avalon-MM master copying a block of 32-bit words between two slave word addresses,
// one read followed by one write per word, in ascending address order.
module avl_copy_master
  import vga_avl_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEFAULT_ADDR_W,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] words_done,
  output logic [ADDR_W-1:0] AVL_M_ADDR,
  output logic              AVL_M_READ,
  output logic              AVL_M_WRITE,
  output logic [3:0]        AVL_M_BYTE_EN,
  output logic [31:0]       AVL_M_WRITEDATA,
  input  logic [31:0]       AVL_M_READDATA,
  input  logic              AVL_M_WAITREQUEST
);

  copy_state_t       state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       buf_q, buf_d;

  logic lat_load;
  logic lat_dec;
  logic lat_expired;

  avl_copy_latency_ctr #(
    .CNT_W (LAT_CNT_W)
  ) u_lat_ctr (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (lat_load),
    .load_val (LAT_CNT_W'(READ_LATENCY)),
    .dec      (lat_dec),
    .expired  (lat_expired)
  );

  always_comb begin
    state_d         = state_q;
    src_d           = src_q;
    dst_d           = dst_q;
    len_d           = len_q;
    idx_d           = idx_q;
    buf_d           = buf_q;
    lat_load        = 1'b0;
    lat_dec         = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    AVL_M_READ      = 1'b0;
    AVL_M_WRITE     = 1'b0;
    AVL_M_ADDR      = '0;
    AVL_M_WRITEDATA = '0;

    unique case (state_q)
      CopyIdle: begin
        busy = 1'b0;
        if (start) begin
          src_d   = src_base;
          dst_d   = dst_base;
          len_d   = length;
          idx_d   = '0;
          state_d = (length == '0) ? CopyFinish : CopyRdReq;
        end
      end

      CopyRdReq: begin
        AVL_M_READ = 1'b1;
        AVL_M_ADDR = src_q + idx_q;
        if (!AVL_M_WAITREQUEST) begin
          if (READ_LATENCY == 0) begin
            buf_d   = AVL_M_READDATA;
            state_d = CopyWrReq;
          end else begin
            lat_load = 1'b1;
            state_d  = CopyRdWait;
          end
        end
      end

      CopyRdWait: begin
        lat_dec = 1'b1;
        if (lat_expired) begin
          buf_d   = AVL_M_READDATA;
          state_d = CopyWrReq;
        end
      end

      CopyWrReq: begin
        AVL_M_WRITE     = 1'b1;
        AVL_M_ADDR      = dst_q + idx_q;
        AVL_M_WRITEDATA = buf_q;
        if (!AVL_M_WAITREQUEST) begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = (idx_d == len_q) ? CopyFinish : CopyRdReq;
        end
      end

      CopyFinish: begin
        done    = 1'b1;
        state_d = CopyIdle;
      end

      default: begin
        state_d = CopyIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= CopyIdle;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  // The word index doubles as the completed-word count: it only advances on write acceptance.
  assign words_done    = idx_q;
  assign AVL_M_BYTE_EN = BYTE_EN_ALL;

endmodule

// File: tb/tb_avl_copy_master.sv
// Self-checking bench for avl_copy_master: stalling slave memory model plus expectation queues.
module tb_avl_copy_master;
  import vga_avl_pkg::*;

  localparam int AW        = 12;
  localparam int RL        = 1;
  localparam int MEM_WORDS = 1 << AW;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          start;
  logic [AW-1:0] src_base, dst_base, length;
  logic          busy, done;
  logic [AW-1:0] words_done;
  logic [AW-1:0] AVL_M_ADDR;
  logic          AVL_M_READ, AVL_M_WRITE;
  logic [3:0]    AVL_M_BYTE_EN;
  logic [31:0]   AVL_M_WRITEDATA, AVL_M_READDATA;
  logic          AVL_M_WAITREQUEST;

  always #5 CLK = ~CLK;

  avl_copy_master #(
    .ADDR_W       (AW),
    .READ_LATENCY (RL)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .start             (start),
    .src_base          (src_base),
    .dst_base          (dst_base),
    .length            (length),
    .busy              (busy),
    .done              (done),
    .words_done        (words_done),
    .AVL_M_ADDR        (AVL_M_ADDR),
    .AVL_M_READ        (AVL_M_READ),
    .AVL_M_WRITE       (AVL_M_WRITE),
    .AVL_M_BYTE_EN     (AVL_M_BYTE_EN),
    .AVL_M_WRITEDATA   (AVL_M_WRITEDATA),
    .AVL_M_READDATA    (AVL_M_READDATA),
    .AVL_M_WAITREQUEST (AVL_M_WAITREQUEST)
  );

  typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int lat; logic [AW-1:0] words; } done_t;
  typedef struct { logic [31:0] data; int due; } rdp_t;

  int errors = 0;
  int checks = 0;

  logic [31:0]   mem    [MEM_WORDS];
  logic [31:0]   shadow [MEM_WORDS];
  logic [AW-1:0] exp_rd [$];
  wr_t           exp_wr [$];
  done_t         exp_done [$];
  rdp_t          rd_pipe [$];

  int cyc = 0;
  int start_cyc = 0;
  int stall_total = 0;
  int stall_max = 0;
  bit stall_rand = 1'b0;
  int rem = -1;
  int done_cnt = 0;
  int done_before = 0;
  int last_lat = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // Slave memory with waitrequest stalls and fixed read latency, plus the checking monitor.
  initial begin : bus
    bit            prev_stall;
    logic [AW-1:0] prev_addr;
    logic [31:0]   prev_wdata;
    logic          prev_rd, prev_wr, wait_now;
    wr_t           w;
    done_t         d;
    prev_stall = 1'b0;
    AVL_M_WAITREQUEST = 1'b1;
    AVL_M_READDATA = '0;
    forever begin
      @(negedge CLK);
      #1;
      cyc++;
      if (start && !busy && !RESET) begin
        start_cyc   = cyc;
        stall_total = 0;
      end
      check("byte_en", 32'(AVL_M_BYTE_EN), 32'hF);
      check("rd_wr_exclusive", 32'(AVL_M_READ & AVL_M_WRITE), 32'h0);
      if (RESET) begin
        rem = -1;
        prev_stall = 1'b0;
        rd_pipe.delete();
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
        AVL_M_WAITREQUEST = 1'b1;
        AVL_M_READDATA = $urandom;
      end else begin
        if (prev_stall) begin
          check("stall_addr", 32'(AVL_M_ADDR), 32'(prev_addr));
          check("stall_read", 32'(AVL_M_READ), 32'(prev_rd));
          check("stall_write", 32'(AVL_M_WRITE), 32'(prev_wr));
          check("stall_wdata", AVL_M_WRITEDATA, prev_wdata);
        end
        wait_now = 1'b0;
        if (AVL_M_READ || AVL_M_WRITE) begin
          if (rem < 0) rem = stall_rand ? int'($urandom_range(stall_max, 0)) : stall_max;
          if (rem > 0) begin
            wait_now = 1'b1;
            rem--;
            stall_total++;
          end else begin
            rem = -1;
            if (AVL_M_READ) begin
              if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got read of %0d, required none", AVL_M_ADDR);
              end else begin
                check("rd_addr", 32'(AVL_M_ADDR), 32'(exp_rd.pop_front()));
              end
              rd_pipe.push_back('{mem[AVL_M_ADDR], cyc + RL});
            end else begin
              if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got write of %0d, required none", AVL_M_ADDR);
              end else begin
                w = exp_wr.pop_front();
                check("wr_addr", 32'(AVL_M_ADDR), 32'(w.addr));
                check("wr_data", AVL_M_WRITEDATA, w.data);
              end
              mem[AVL_M_ADDR] = AVL_M_WRITEDATA;
            end
          end
          AVL_M_WAITREQUEST = wait_now;
        end else begin
          AVL_M_WAITREQUEST = 1'($urandom_range(1, 0));
        end
        prev_stall = wait_now;
        prev_addr  = AVL_M_ADDR;
        prev_rd    = AVL_M_READ;
        prev_wr    = AVL_M_WRITE;
        prev_wdata = AVL_M_WRITEDATA;
        if (rd_pipe.size() > 0 && rd_pipe[0].due == cyc) begin
          AVL_M_READDATA = rd_pipe.pop_front().data;
        end else begin
          AVL_M_READDATA = $urandom;
        end
        if (done) begin
          done_cnt++;
          last_lat = cyc - start_cyc + 1;
          check("busy_in_finish", 32'(busy), 32'h1);
          if (exp_done.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done pulse, required none");
          end else begin
            d = exp_done.pop_front();
            check("latency", 32'(last_lat), 32'(d.lat + stall_total));
            check("words_done", 32'(words_done), 32'(d.words));
          end
        end
      end
    end
  end

  // Reference copy on a snapshot of memory: word k moves src+k to dst+k, ascending, modulo 2^AW.
  task automatic start_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [AW-1:0] l);
    logic [AW-1:0] a, b;
    shadow = mem;
    for (int k = 0; k < int'(l); k++) begin
      a = s + AW'(k);
      b = d + AW'(k);
      exp_rd.push_back(a);
      exp_wr.push_back('{b, shadow[a]});
      shadow[b] = shadow[a];
    end
    exp_done.push_back('{2 + int'(l) * (2 + RL), l});
    done_before = done_cnt;
    src_base = s;
    dst_base = d;
    length   = l;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    src_base = AW'($urandom);
    dst_base = AW'($urandom);
    length   = AW'($urandom);
  endtask

  task automatic finish_copy(input logic [AW-1:0] l, input int exp_lat);
    int n;
    n = 0;
    while (done_cnt == done_before && n < 1000) begin
      tick();
      n++;
    end
    if (exp_lat >= 0) check("total_cycles", 32'(last_lat), 32'(exp_lat));
    repeat (3) tick();
    check("single_done", 32'(done_cnt - done_before), 32'h1);
    check("idle_busy", 32'(busy), 32'h0);
    check("words_hold", 32'(words_done), 32'(l));
    check("reads_left", 32'(exp_rd.size()), 32'h0);
    check("writes_left", 32'(exp_wr.size()), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_req"}, 32'({AVL_M_READ, AVL_M_WRITE}), 32'h0);
    check({tag, "_addr"}, 32'(AVL_M_ADDR), 32'h0);
    check({tag, "_wdata"}, AVL_M_WRITEDATA, 32'h0);
    check({tag, "_words"}, 32'(words_done), 32'h0);
    check({tag, "_be"}, 32'(AVL_M_BYTE_EN), 32'hF);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [AW-1:0] s, d, l;
    RESET = 1'b1;
    start = 1'b0;
    src_base = '0;
    dst_base = '0;
    length   = '0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    for (int k = 0; k < 4; k++) mem[10 + k] = 32'hA0 + 32'(k);
    repeat (2) tick();
    RESET = 1'b0;
    check_reset_outputs("reset");
    tick();

    stall_rand = 1'b0;
    stall_max  = 0;
    start_copy(AW'(10), AW'(WALL_POS_BASE), AW'(4));
    finish_copy(AW'(4), 14);
    for (int k = 0; k < 4; k++) check("basic_mem", mem[WALL_POS_BASE + k], 32'hA0 + 32'(k));

    stall_max = 3;
    start_copy(AW'(10), AW'(WALL_POS_BASE + 8), AW'(4));
    finish_copy(AW'(4), 38);
    for (int k = 0; k < 4; k++) check("stall_mem", mem[WALL_POS_BASE + 8 + k], 32'hA0 + 32'(k));

    stall_max = 0;
    start_copy(AW'(100), AW'(200), AW'(0));
    finish_copy(AW'(0), 2);

    stall_rand = 1'b1;
    stall_max  = 2;
    start_copy(AW'(4094), AW'(4095), AW'(3));
    finish_copy(AW'(3), -1);

    // Reset while the second of five writes is being presented.
    stall_rand = 1'b0;
    stall_max  = 0;
    s = AW'(300);
    d = AW'(PALETTE_BASE);
    start_copy(s, d, AW'(5));
    for (int n = 0; n < 50; n++) begin
      tick();
      if (AVL_M_WRITE && AVL_M_ADDR == d + AW'(1)) break;
    end
    check("mid_reset_reached", 32'(AVL_M_WRITE), 32'h1);
    RESET = 1'b1;
    tick();
    check_reset_outputs("mid_reset");
    RESET = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("post_reset_quiet", 32'({AVL_M_READ, AVL_M_WRITE, busy}), 32'h0);
    end
    check("post_reset_done", 32'(done_cnt - done_before), 32'h0);
    start_copy(AW'(310), AW'(PALETTE_BASE + 16), AW'(3));
    finish_copy(AW'(3), 11);

    // A second start while busy must be ignored.
    start_copy(AW'(500), AW'(CTRL_REG), AW'(6));
    repeat (4) tick();
    src_base = AW'(900);
    dst_base = AW'(950);
    length   = AW'(2);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    finish_copy(AW'(6), 20);

    stall_rand = 1'b1;
    for (int it = 0; it < 12; it++) begin
      s = AW'($urandom_range(VRAM_WORDS - 1, 0));
      if (it % 3 == 0) d = s + AW'($urandom_range(3, 0));
      else d = AW'($urandom_range(CTRL_REG, PALETTE_BASE));
      l = AW'($urandom_range(8, 1));
      start_copy(s, d, l);
      finish_copy(l, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avl_copy_master.md
Name: avl_copy_master

Overview:
- Avalon-MM master that copies a block of 32-bit words from one slave word address to another.
- Each word is a read transfer followed by a write transfer.
- Used to bulk-load palette, wall-position and attribute registers, or to scroll VRAM rows, in the VGA text/tank slave without CPU involvement.
- Sits on the same 50 MHz system clock as the slave, beside the CPU master on the interconnect.

Parameters:
- ADDR_W, 12, word-address width of source, destination and length.
- READ_LATENCY, 1, fixed slave read latency in cycles after the read is accepted; legal range 0..3.

Ports:
- CLK  input  1  system clock, also the Avalon clock.
- RESET  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; sampled only in IDLE.
- src_base  input  ADDR_W  first source word address.
- dst_base  input  ADDR_W  first destination word address.
- length  input  ADDR_W  number of words to copy.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a copy completes.
- words_done  output  ADDR_W  words written so far in the current or last copy.
- AVL_M_ADDR  output  ADDR_W  master word address.
- AVL_M_READ  output  1  read request.
- AVL_M_WRITE  output  1  write request.
- AVL_M_BYTE_EN  output  4  byte enables.
- AVL_M_WRITEDATA  output  32  write data.
- AVL_M_READDATA  input  32  read data.
- AVL_M_WAITREQUEST  input  1  slave stall.

Behaviour:
- Reset (synchronous, wins over everything, including mid-copy):
  - State goes to IDLE.
  - busy, done, AVL_M_READ and AVL_M_WRITE are 0.
  - AVL_M_ADDR, AVL_M_WRITEDATA and words_done are 0.
  - AVL_M_BYTE_EN is 4'hF.
  - Any in-flight transfer is abandoned; no further request is issued.
- AVL_M_BYTE_EN is always 4'hF. AVL_M_READ and AVL_M_WRITE are never high together.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH.
- IDLE:
  - On start=1, latch src_base, dst_base and length; clear the index i and words_done.
  - If length=0, go to FINISH; otherwise go to RD_REQ.
  - start while busy is ignored.
- RD_REQ:
  - Drive AVL_M_READ=1 and AVL_M_ADDR=src+i, held stable while AVL_M_WAITREQUEST=1.
  - On the cycle AVL_M_WAITREQUEST=0 the read is accepted.
  - If READ_LATENCY=0, capture AVL_M_READDATA in that same cycle and go to WR_REQ.
  - Otherwise load the latency counter with READ_LATENCY and go to RD_WAIT.
- RD_WAIT:
  - AVL_M_READ=0; decrement the counter each cycle.
  - Capture AVL_M_READDATA into the data buffer READ_LATENCY cycles after acceptance, then go to WR_REQ.
- WR_REQ:
  - Drive AVL_M_WRITE=1, AVL_M_ADDR=dst+i and AVL_M_WRITEDATA=buffer, held while AVL_M_WAITREQUEST=1.
  - On acceptance, increment i and words_done.
  - If the new i equals length, go to FINISH; otherwise go to RD_REQ in the next cycle.
- FINISH: done=1 for exactly one cycle, busy=1, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W: src+i and dst+i wrap past 4095 to 0.
- Overlapping ranges are copied strictly in ascending order; no overlap correction.
- Per-word cost with zero wait states: 1 (read) + READ_LATENCY + 1 (write) cycles.
- Total copy latency from the start cycle to the done pulse: length*(2+READ_LATENCY) + 2 cycles.
- words_done holds its final value in IDLE until the next accepted start.

Decomposition:
- Shared package vga_avl_pkg holds:
  - copy_state_t enum;
  - ADDR_W default;
  - register-map constants (PALETTE_BASE=2048, CTRL_REG=2056, WALL_POS_BASE=2067, VRAM_WORDS=1200) so software-equivalent copies use named addresses.
- One natural sub-module, avl_copy_latency_ctr: a load/decrement counter that raises an expired flag.
- Everything else stays in avl_copy_master.

Test Plan:
- Basic copy, zero wait states, READ_LATENCY=1: memory model holds 32'hA0+k at addresses 10..13; start with src=10, dst=2067, length=4.
  - Required: four writes to 2067..2070 with data 32'hA0..32'hA3.
  - Required: done pulses at cycle 14 after start; words_done=4.
- Waitrequest stalls: hold AVL_M_WAITREQUEST=1 for 3 cycles on every read and every write.
  - Required: address, data and request held stable during each stall.
  - Required: same data copied; total cycles = 4*(2+1+6)+2 = 38.
- length=0: start with length=0.
  - Required: no AVL_M_READ or AVL_M_WRITE; done at cycle 2; words_done=0.
- Wrap-around: src=4094, dst=4095, length=3.
  - Required: reads from 4094, 4095, 0; writes to 4095, 0, 1.
- Reset mid-copy: assert RESET during WR_REQ of word 2 of 5.
  - Required: the next cycle has all outputs at their reset values and state IDLE; no further bus activity; a new start then copies correctly.
- Start while busy: pulse start with different bases during a copy.
  - Required: ignored; the original copy completes unchanged with a single done pulse.
